// File: rtl/hanning_window.sv
// Hann windowing stage: streams the speech frame through a symmetric window
// held as a half-window ROM and writes saturated Q16 products into Sn RAM.
//
// state | meaning
// IDLE  | waiting for startw, all outputs low
// RUN   | issuing one speech/window read per cycle, k = 0..NSAM-1
// FLUSH | no new reads, draining the pipeline until index NSAM-1 is written
// DONE  | donew high, held until startw drops
module hanning_window #(
    parameter int N    = 32,
    parameter int Q    = 16,
    parameter int NSAM = 320
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         startw,
    output logic         donew,
    output logic [8:0]   speech_addr,
    input  logic [N-1:0] speech_rdata,
    output logic [7:0]   win_addr,
    input  logic [N-1:0] win_rdata,
    output logic [8:0]   sn_addr,
    output logic [N-1:0] sn_wdata,
    output logic         sn_we
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [8:0]   LAST  = 9'(NSAM - 1);
    localparam logic [8:0]   HALF  = 9'(NSAM / 2);
    localparam logic [N-1:0] SAT_P = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_N = {1'b1, {(N-1){1'b0}}};

    state_t       state_q, state_d;
    logic [8:0]   k_q, k_d;
    logic         rd_v_q, rd_v_d;
    logic [8:0]   speech_addr_q, speech_addr_d;
    logic [7:0]   win_addr_q, win_addr_d;
    logic [8:0]   idx1_q;
    logic         v1_q;
    logic         sn_we_q;
    logic [8:0]   sn_addr_q;
    logic [N-1:0] sn_wdata_q;

    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] shifted;
    logic                  ovf;
    logic [N-1:0]          sat;

    // Full-width product, floor shift by Q, clamp to the N-bit range.
    // Overflow exactly when the bits above the result sign disagree with it.
    assign prod    = $signed(speech_rdata) * $signed(win_rdata);
    assign shifted = prod >>> Q;
    assign ovf     = !((&shifted[2*N-1:N-1]) || !(|shifted[2*N-1:N-1]));
    assign sat     = ovf ? (shifted[2*N-1] ? SAT_N : SAT_P) : shifted[N-1:0];

    // Control state and read-issue registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            rd_v_q        <= 1'b0;
            speech_addr_q <= '0;
            win_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            rd_v_q        <= rd_v_d;
            speech_addr_q <= speech_addr_d;
            win_addr_q    <= win_addr_d;
        end
    end

    // Next state, frame counter and read addresses for the coming cycle.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        rd_v_d        = 1'b0;
        speech_addr_d = '0;
        win_addr_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (startw) begin
                    state_d = S_RUN;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                rd_v_d        = 1'b1;
                speech_addr_d = k_q;
                // Second half of the frame mirrors onto the same ROM entries.
                win_addr_d    = (k_q < HALF) ? k_q[7:0] : 8'(LAST - k_q);
                if (k_q == LAST) begin
                    state_d = S_FLUSH;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            S_FLUSH: begin
                if (sn_we_q && (sn_addr_q == LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!startw) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Index tracks the RAM latency; output register captures the product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx1_q     <= '0;
            v1_q       <= 1'b0;
            sn_we_q    <= 1'b0;
            sn_addr_q  <= '0;
            sn_wdata_q <= '0;
        end else begin
            idx1_q     <= speech_addr_q;
            v1_q       <= rd_v_q;
            sn_we_q    <= v1_q;
            sn_addr_q  <= v1_q ? idx1_q : '0;
            sn_wdata_q <= v1_q ? sat : '0;
        end
    end

    assign donew       = (state_q == S_DONE);
    assign speech_addr = speech_addr_q;
    assign win_addr    = win_addr_q;
    assign sn_we       = sn_we_q;
    assign sn_addr     = sn_addr_q;
    assign sn_wdata    = sn_wdata_q;

endmodule

// File: tb/tb_hanning_window.sv
// Bench for hanning_window: synchronous RAM/ROM models, arithmetic reference
// model, directed frames plus randomized data and handshake toggling.
module tb_hanning_window;

    localparam int N    = 32;
    localparam int NSAM = 320;
    localparam int HALF = NSAM / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          startw;
    logic          donew;
    logic [8:0]    speech_addr;
    logic [N-1:0]  speech_rdata;
    logic [7:0]    win_addr;
    logic [N-1:0]  win_rdata;
    logic [8:0]    sn_addr;
    logic [N-1:0]  sn_wdata;
    logic          sn_we;

    logic [31:0] speech_mem [NSAM];
    logic [31:0] win_mem    [HALF];
    logic [31:0] exp_w      [NSAM];
    logic [31:0] got_w      [NSAM];

    int n_checks = 0;
    int n_errors = 0;

    hanning_window #(.N(N), .Q(16), .NSAM(NSAM)) dut (
        .clk          (clk),
        .rst          (rst),
        .startw       (startw),
        .donew        (donew),
        .speech_addr  (speech_addr),
        .speech_rdata (speech_rdata),
        .win_addr     (win_addr),
        .win_rdata    (win_rdata),
        .sn_addr      (sn_addr),
        .sn_wdata     (sn_wdata),
        .sn_we        (sn_we)
    );

    always #5 clk = ~clk;

    // One-cycle-latency speech RAM and window ROM.
    always @(posedge clk) begin
        speech_rdata <= (int'(speech_addr) < NSAM) ? speech_mem[int'(speech_addr)] : 32'hDEAD_BEEF;
        win_rdata    <= (int'(win_addr) < HALF) ? win_mem[int'(win_addr)] : 32'hDEAD_BEEF;
    end

    // Q16 multiply: exact product, floor divide by 2^16, clamp to 32-bit signed.
    function automatic logic [31:0] ref_mul(input logic [31:0] s, input logic [31:0] w);
        longint p;
        p = longint'($signed(s)) * longint'($signed(w));
        p = p >>> 16;
        if (p > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
        return p[31:0];
    endfunction

    function automatic void compute_expected();
        for (int k = 0; k < NSAM; k++)
            exp_w[k] = ref_mul(speech_mem[k], win_mem[(k < HALF) ? k : NSAM - 1 - k]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_donew"}, 32'(donew), 32'd0);
        chk({tag, "_sn_we"}, 32'(sn_we), 32'd0);
        chk({tag, "_speech_addr"}, 32'(speech_addr), 32'd0);
        chk({tag, "_win_addr"}, 32'(win_addr), 32'd0);
        chk({tag, "_sn_addr"}, 32'(sn_addr), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        startw = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_quiet("idle");
        end
    endtask

    // Starts a frame from IDLE (edge 0 = startw sampled) and checks every cycle.
    // abort_at > 0 pulls rst low at that edge and returns after checking reset.
    task automatic run_frame(input int abort_at, input bit toggle, input int hold);
        bit we_exp;
        compute_expected();
        startw = 1'b1;
        tick();
        for (int c = 1; c <= NSAM + 3; c++) begin
            startw = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_at > 0 && c == abort_at) rst = 1'b0;
            tick();
            if (abort_at > 0 && c == abort_at) begin
                chk_quiet("reset_mid");
                chk("reset_mid_sn_wdata", sn_wdata, 32'd0);
                rst    = 1'b1;
                startw = 1'b0;
                return;
            end
            if (c <= NSAM) begin
                chk("speech_addr", 32'(speech_addr), 32'(c - 1));
                chk("win_addr", 32'(win_addr), 32'((c - 1 < HALF) ? c - 1 : NSAM - c));
            end
            we_exp = (c >= 3) && (c <= NSAM + 2);
            chk("sn_we", 32'(sn_we), 32'(we_exp));
            if (we_exp) begin
                chk("sn_addr", 32'(sn_addr), 32'(c - 3));
                chk("sn_wdata", sn_wdata, exp_w[c - 3]);
                got_w[c - 3] = sn_wdata;
            end
            chk("donew", 32'(donew), 32'(c == NSAM + 3));
        end
        startw = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("donew_hold", 32'(donew), 32'd1);
            chk("sn_we_done", 32'(sn_we), 32'd0);
        end
        startw = 1'b0;
        tick();
        chk("donew_clear", 32'(donew), 32'd0);
        chk("sn_we_after", 32'(sn_we), 32'd0);
    endtask

    initial begin
        rst    = 1'b0;
        startw = 1'b0;
        for (int k = 0; k < NSAM; k++) speech_mem[k] = '0;
        for (int i = 0; i < HALF; i++) win_mem[i] = '0;
        repeat (3) tick();
        chk_quiet("reset");
        chk("reset_sn_wdata", sn_wdata, 32'd0);
        rst = 1'b1;
        idle_cycles(2);

        // Ramp through a unity window.
        for (int k = 0; k < NSAM; k++) speech_mem[k] = 32'(k) << 16;
        for (int i = 0; i < HALF; i++) win_mem[i] = 32'h0001_0000;
        run_frame(0, 1'b0, 3);
        idle_cycles(3);

        // Symmetry: window ROM holds its own index, unity speech.
        for (int k = 0; k < NSAM; k++) speech_mem[k] = 32'h0001_0000;
        for (int i = 0; i < HALF; i++) win_mem[i] = 32'(i);
        run_frame(0, 1'b1, 0);

        // Signed truncation and saturation corners, started at minimum interval.
        for (int k = 0; k < NSAM; k++) speech_mem[k] = $urandom();
        for (int i = 0; i < HALF; i++) win_mem[i] = 32'($urandom_range(0, 32'h0001_0000));
        speech_mem[0] = 32'hFFFE_8000; win_mem[0] = 32'h0000_8000;
        speech_mem[1] = 32'h0000_0001; win_mem[1] = 32'h0000_8000;
        speech_mem[2] = 32'hFFFF_FFFF; win_mem[2] = 32'h0000_8000;
        speech_mem[3] = 32'h7FFF_0000; win_mem[3] = 32'h0002_0000;
        speech_mem[4] = 32'h8000_0000; win_mem[4] = 32'h0002_0000;
        run_frame(0, 1'b1, 2);
        chk("neg_trunc", got_w[0], 32'hFFFF_4000);
        chk("small_trunc", got_w[1], 32'h0000_0000);
        chk("minus_lsb", got_w[2], 32'hFFFF_FFFF);
        chk("sat_pos", got_w[3], 32'h7FFF_FFFF);
        chk("sat_neg", got_w[4], 32'h8000_0000);
        idle_cycles(2);

        // Reset at cycle 100, then a full restart from index 0.
        for (int k = 0; k < NSAM; k++) speech_mem[k] = $urandom();
        for (int i = 0; i < HALF; i++) win_mem[i] = 32'($urandom_range(0, 32'h0001_0000));
        run_frame(100, 1'b1, 0);
        idle_cycles(2);
        run_frame(0, 1'b1, 1);
        idle_cycles(1);

        // Fully random words, exercising saturation both ways.
        for (int k = 0; k < NSAM; k++) speech_mem[k] = $urandom();
        for (int i = 0; i < HALF; i++) win_mem[i] = $urandom();
        run_frame(0, 1'b1, 2);
        idle_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
